// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD from the SDR byte stream and emits framed bytes.
// Optional in-band status capture is enabled by defining RGMII_RX_INBAND_STATUS_EN.
module rgmii_rx_framer #(
   parameter int MAX_FRAME_LEN = 1522,
   parameter int MIN_PREAMBLE  = 1
) (
   input  logic       rx_clk,
   input  logic       reset,
   input  logic [3:0] rxd_a,
   input  logic [3:0] rxd_b,
   input  logic       rx_ctl_a,
   input  logic       rx_ctl_b,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_sof,
   output logic       rx_eof,
   output logic       rx_err,
   output logic       link_up,
   output logic [1:0] speed,
   output logic       full_duplex
);

   localparam int CNT_W = $clog2(MAX_FRAME_LEN + 2);

   typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

   logic [7:0]       w_byte;
   logic             w_dv;
   logic             w_er;
   logic             w_pre_ok;
   logic             w_cnt_full;

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_pre_cnt, w_pre_cnt_nxt;
   logic [7:0]       r_hold, w_hold_nxt;
   logic             r_hold_vld, w_hold_vld_nxt;
   logic             r_first, w_first_nxt;
   logic             r_sticky, w_sticky_nxt;
   logic [CNT_W-1:0] r_byte_cnt, w_byte_cnt_nxt;

   logic [7:0]       w_data_nxt;
   logic             w_valid_nxt, w_sof_nxt, w_eof_nxt, w_err_nxt;

   assign w_byte     = {rxd_b, rxd_a};
   assign w_dv       = rx_ctl_a;
   assign w_er       = rx_ctl_a ^ rx_ctl_b;
   assign w_pre_ok   = (int'(r_pre_cnt) >= MIN_PREAMBLE);
   // Accepting one more byte would push the frame past its maximum length.
   assign w_cnt_full = (int'(r_byte_cnt) >= MAX_FRAME_LEN);

   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_pre_cnt  <= 3'd0;
         r_hold     <= 8'h00;
         r_hold_vld <= 1'b0;
         r_first    <= 1'b0;
         r_sticky   <= 1'b0;
         r_byte_cnt <= '0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         rx_sof     <= 1'b0;
         rx_eof     <= 1'b0;
         rx_err     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pre_cnt  <= w_pre_cnt_nxt;
         r_hold     <= w_hold_nxt;
         r_hold_vld <= w_hold_vld_nxt;
         r_first    <= w_first_nxt;
         r_sticky   <= w_sticky_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         rx_data    <= w_data_nxt;
         rx_valid   <= w_valid_nxt;
         rx_sof     <= w_sof_nxt;
         rx_eof     <= w_eof_nxt;
         rx_err     <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pre_cnt_nxt  = r_pre_cnt;
      w_hold_nxt     = r_hold;
      w_hold_vld_nxt = r_hold_vld;
      w_first_nxt    = r_first;
      w_sticky_nxt   = r_sticky;
      w_byte_cnt_nxt = r_byte_cnt;
      w_data_nxt     = rx_data;
      w_valid_nxt    = 1'b0;
      w_sof_nxt      = 1'b0;
      w_eof_nxt      = 1'b0;
      w_err_nxt      = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_dv) begin
               if (w_byte == 8'h55) begin
                  w_state_nxt   = S_PREAMBLE;
                  w_pre_cnt_nxt = 3'd1;
               end else begin
                  w_state_nxt = S_DROP;
               end
            end
         end

         S_PREAMBLE: begin
            if (!w_dv) begin
               w_state_nxt = S_IDLE;
            end else if (w_byte == 8'h55) begin
               if (r_pre_cnt != 3'd7)
                  w_pre_cnt_nxt = r_pre_cnt + 3'd1;
            end else if (w_byte == 8'hD5 && w_pre_ok) begin
               w_state_nxt    = S_DATA;
               w_hold_vld_nxt = 1'b0;
               w_first_nxt    = 1'b1;
               w_sticky_nxt   = 1'b0;
               w_byte_cnt_nxt = '0;
            end else begin
               w_state_nxt = S_DROP;
            end
         end

         S_DATA: begin
            if (!w_dv) begin
               // End of frame: flush the held byte as the last one.
               if (r_hold_vld) begin
                  w_data_nxt  = r_hold;
                  w_valid_nxt = 1'b1;
                  w_sof_nxt   = r_first;
                  w_eof_nxt   = 1'b1;
                  w_err_nxt   = r_sticky;
               end
               w_hold_vld_nxt = 1'b0;
               w_first_nxt    = 1'b0;
               w_state_nxt    = S_IDLE;
            end else if (w_cnt_full) begin
               // Oversize: close the frame on the held byte and discard the rest.
               if (r_hold_vld) begin
                  w_data_nxt  = r_hold;
                  w_valid_nxt = 1'b1;
                  w_sof_nxt   = r_first;
                  w_eof_nxt   = 1'b1;
                  w_err_nxt   = 1'b1;
               end
               w_hold_vld_nxt = 1'b0;
               w_first_nxt    = 1'b0;
               w_state_nxt    = S_DROP;
            end else begin
               if (r_hold_vld) begin
                  w_data_nxt  = r_hold;
                  w_valid_nxt = 1'b1;
                  w_sof_nxt   = r_first;
                  w_first_nxt = 1'b0;
               end
               w_hold_nxt     = w_byte;
               w_hold_vld_nxt = 1'b1;
               w_sticky_nxt   = r_sticky | w_er;
               if (r_byte_cnt != {CNT_W{1'b1}})
                  w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
            end
         end

         S_DROP: begin
            if (!w_dv)
               w_state_nxt = S_IDLE;
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef RGMII_RX_INBAND_STATUS_EN
   // Inter-frame RXD carries link/speed/duplex when RX_CTL is idle.
   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         link_up     <= 1'b0;
         speed       <= 2'b00;
         full_duplex <= 1'b0;
      end else if (r_state == S_IDLE && !w_dv && !w_er) begin
         link_up     <= rxd_a[0];
         speed       <= rxd_a[2:1];
         full_duplex <= rxd_a[3];
      end
   end
`else
   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         link_up     <= 1'b0;
         speed       <= 2'b00;
         full_duplex <= 1'b0;
      end else begin
         link_up     <= 1'b1;
         speed       <= 2'b10;
         full_duplex <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Randomized bench for rgmii_rx_framer: two instances (default and MAX_FRAME_LEN=16/MIN_PREAMBLE=3)
// share one stimulus stream and are compared against a frame-level reference model every cycle.
module tb_rgmii_rx_framer;

   localparam int MAXC = 8192;

   typedef struct packed {
      logic       rst;
      logic       dv;
      logic       er;
      logic [7:0] b;
   } stim_t;

   logic       rx_clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] rxd_a = 4'h0;
   logic [3:0] rxd_b = 4'h0;
   logic       rx_ctl_a = 1'b0;
   logic       rx_ctl_b = 1'b0;

   logic [7:0] a_data, b_data;
   logic       a_valid, a_sof, a_eof, a_err, a_link, a_fd;
   logic       b_valid, b_sof, b_eof, b_err, b_link, b_fd;
   logic [1:0] a_speed, b_speed;

   rgmii_rx_framer u_dut_a (
      .rx_clk(rx_clk), .reset(reset), .rxd_a(rxd_a), .rxd_b(rxd_b),
      .rx_ctl_a(rx_ctl_a), .rx_ctl_b(rx_ctl_b),
      .rx_data(a_data), .rx_valid(a_valid), .rx_sof(a_sof), .rx_eof(a_eof), .rx_err(a_err),
      .link_up(a_link), .speed(a_speed), .full_duplex(a_fd));

   rgmii_rx_framer #(.MAX_FRAME_LEN(16), .MIN_PREAMBLE(3)) u_dut_b (
      .rx_clk(rx_clk), .reset(reset), .rxd_a(rxd_a), .rxd_b(rxd_b),
      .rx_ctl_a(rx_ctl_a), .rx_ctl_b(rx_ctl_b),
      .rx_data(b_data), .rx_valid(b_valid), .rx_sof(b_sof), .rx_eof(b_eof), .rx_err(b_err),
      .link_up(b_link), .speed(b_speed), .full_duplex(b_fd));

   always #5 rx_clk = ~rx_clk;

   stim_t       stim[$];
   logic [11:0] exp_t [0:MAXC-1];
   logic [11:0] exp_a [0:MAXC-1];
   logic [11:0] exp_b [0:MAXC-1];
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   task automatic put(input logic rst, input logic dv, input logic er, input logic [7:0] b);
      stim.push_back({rst, dv, er, b});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
   endtask

   task automatic preamble(input int n);
      for (int i = 0; i < n; i++) put(1'b0, 1'b1, 1'b0, 8'h55);
      put(1'b0, 1'b1, 1'b0, 8'hD5);
   endtask

   task automatic rand_frame();
      int         kind;
      int         len;
      logic [7:0] x;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
         x = 8'($urandom);
         if (x == 8'h55) x = 8'h12;
         put(1'b0, 1'b1, 1'b0, x);
         len = $urandom_range(0, 8);
         for (int i = 0; i < len; i++) put(1'b0, 1'b1, 1'b0, 8'($urandom));
      end else if (kind == 1) begin
         len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) put(1'b0, 1'b1, 1'b0, 8'h55);
         x = 8'($urandom);
         if (x == 8'h55 || x == 8'hD5) x = 8'h3C;
         put(1'b0, 1'b1, 1'b0, x);
         len = $urandom_range(0, 6);
         for (int i = 0; i < len; i++) put(1'b0, 1'b1, 1'b0, 8'($urandom));
      end else begin
         preamble($urandom_range(1, 8));
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 70) : $urandom_range(0, 20);
         for (int i = 0; i < len; i++)
            put(1'b0, 1'b1, 1'($urandom_range(0, 29) == 0), 8'($urandom));
      end
      idle($urandom_range(1, 4));
   endtask

   // Frame-level reference: every accepted data byte surfaces one sample after the
   // following input cycle; reset kills the byte still held and any eof.
   task automatic model(input int max_len, input int min_pre);
      int n, j, s, t, i, k, d0, L, ne, last;
      bit aborted, anyer;
      n = stim.size();
      for (int c = 0; c < MAXC; c++) exp_t[c] = '0;
      j = 0;
      while (j < n) begin
         if (stim[j].dv && !stim[j].rst && (j == 0 || !stim[j-1].dv || stim[j-1].rst)) begin
            s = j;
            t = j;
            while (t < n && stim[t].dv && !stim[t].rst) t++;
            aborted = (t >= n) || stim[t].rst;
            i = s;
            while (i < t && stim[i].b == 8'h55) i++;
            k = i - s;
            if (k > 0 && i < t && stim[i].b == 8'hD5 && ((k > 7) ? 7 : k) >= min_pre) begin
               d0 = i + 1;
               L = t - d0;
               anyer = 1'b0;
               for (int m = 0; m < L && m < max_len; m++) anyer |= stim[d0+m].er;
               if (L > max_len) begin
                  for (int m = 0; m < max_len; m++)
                     exp_t[d0+m+1] = {1'b1, (m == 0), (m == max_len-1), (m == max_len-1), stim[d0+m].b};
               end else begin
                  ne = aborted ? L - 1 : L;
                  for (int m = 0; m < ne; m++) begin
                     last = (!aborted && m == L - 1) ? 1 : 0;
                     exp_t[d0+m+1] = {1'b1, (m == 0), (last == 1), (last == 1) && anyer, stim[d0+m].b};
                  end
               end
            end
            j = t;
         end else begin
            j++;
         end
      end
   endtask

   initial begin
      stim_t c;
      for (int i = 0; i < 4; i++) put(1'b1, 1'b0, 1'b0, 8'h00);
      idle(3);
      // 64-byte frame, then the same with an error on 0x10, then clean again
      for (int f = 0; f < 3; f++) begin
         preamble(7);
         for (int i = 1; i <= 64; i++) put(1'b0, 1'b1, (f == 1 && i == 16), 8'(i));
         idle(3);
      end
      // broken preamble, then a good frame
      put(1'b0, 1'b1, 1'b0, 8'h55); put(1'b0, 1'b1, 1'b0, 8'h55); put(1'b0, 1'b1, 1'b0, 8'hAA);
      for (int i = 0; i < 5; i++) put(1'b0, 1'b1, 1'b0, 8'($urandom));
      idle(2);
      preamble(7);
      for (int i = 0; i < 20; i++) put(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
      idle(3);
      // zero-byte and one-byte frames
      preamble(1); idle(2);
      preamble(3); put(1'b0, 1'b1, 1'b0, 8'h42); idle(2);
      // reset after the fifth data byte with dv still high across release
      preamble(7);
      for (int i = 1; i <= 5; i++) put(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
      for (int i = 0; i < 3; i++) put(1'b1, 1'b1, 1'b0, 8'hB0);
      put(1'b0, 1'b1, 1'b0, 8'h66); put(1'b0, 1'b1, 1'b0, 8'h77);
      idle(3);
      preamble(7);
      for (int i = 0; i < 10; i++) put(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
      idle(3);
      for (int f = 0; f < 30; f++) rand_frame();
      idle(4);

      model(1522, 1);
      exp_a = exp_t;
      model(16, 3);
      exp_b = exp_t;

      for (int j = 0; j < stim.size(); j++) begin
         c = stim[j];
         reset    = c.rst;
         rx_ctl_a = c.dv;
         rx_ctl_b = c.dv ^ c.er;
         rxd_a    = c.b[3:0];
         rxd_b    = c.b[7:4];
         @(posedge rx_clk);
         #1;
         chk($sformatf("a_out@%0d", j),
             {20'h0, a_valid, a_sof, a_eof, a_err, a_valid ? a_data : 8'h00}, {20'h0, exp_a[j]});
         chk($sformatf("b_out@%0d", j),
             {20'h0, b_valid, b_sof, b_eof, b_err, b_valid ? b_data : 8'h00}, {20'h0, exp_b[j]});
         if (c.rst) begin
            chk($sformatf("a_rst@%0d", j), {20'h0, a_data, a_link, a_speed, a_fd}, 32'h0);
            chk($sformatf("b_rst@%0d", j), {20'h0, b_data, b_link, b_speed, b_fd}, 32'h0);
         end else begin
`ifndef RGMII_RX_INBAND_STATUS_EN
            chk($sformatf("a_stat@%0d", j), {28'h0, a_link, a_speed, a_fd}, 32'hD);
            chk($sformatf("b_stat@%0d", j), {28'h0, b_link, b_speed, b_fd}, 32'hD);
`endif
         end
      end

      // idle status pattern 4'b1101 -> link up, 1000M, full duplex
      reset    = 1'b0;
      rx_ctl_a = 1'b0;
      rx_ctl_b = 1'b0;
      rxd_a    = 4'b1101;
      rxd_b    = 4'h0;
      repeat (4) @(posedge rx_clk);
      #1;
      chk("a_status", {28'h0, a_link, a_speed, a_fd}, 32'hD);
      chk("b_status", {28'h0, b_link, b_speed, b_fd}, 32'hD);
      chk("a_quiet", {31'h0, a_valid}, 32'h0);
      chk("b_quiet", {31'h0, b_valid}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rgmii_rx_framer.md
RGMII_RX_FRAMER -- requirements
Module: rgmii_rx_framer

Interface
REQ-001 Parameter MAX_FRAME_LEN, default 1522, maximum data bytes (after SFD) accepted per frame.
REQ-002 Parameter MIN_PREAMBLE, default 1, minimum 0x55 bytes required before SFD.
REQ-003 rx_clk  in  1  single clock; receive clock domain of the SDR side of the RGMII converter.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rxd_a  in  4  low nibble, rising-edge RGMII sample.
REQ-006 rxd_b  in  4  high nibble, falling-edge RGMII sample.
REQ-007 rx_ctl_a  in  1  RX_DV (rising-edge RX_CTL).
REQ-008 rx_ctl_b  in  1  RX_DV xor RX_ER (falling-edge RX_CTL).
REQ-009 rx_data  out  8  frame byte, preamble/SFD stripped.
REQ-010 rx_valid  out  1  rx_data valid this cycle.
REQ-011 rx_sof  out  1  first data byte of frame; qualified by rx_valid.
REQ-012 rx_eof  out  1  last data byte of frame; qualified by rx_valid.
REQ-013 rx_err  out  1  frame bad; meaningful only with rx_eof.
REQ-014 link_up  out  1  in-band link status.
REQ-015 speed  out  2  in-band speed: 00=10M, 01=100M, 10=1000M.
REQ-016 full_duplex  out  1  in-band duplex status.

Function
REQ-017 Each cycle, byte = {rxd_b, rxd_a}, dv = rx_ctl_a, er = rx_ctl_a ^ rx_ctl_b.
REQ-018 FSM states IDLE, PREAMBLE, DATA, DROP; reset state IDLE.
REQ-019 IDLE: dv=1 and byte=0x55 -> PREAMBLE, preamble count=1; dv=1 and any other byte -> DROP.
REQ-020 PREAMBLE: byte=0x55 -> stay, count saturates at 7; byte=0xD5 with count>=MIN_PREAMBLE -> DATA; byte=0xD5 with count<MIN_PREAMBLE or any other byte -> DROP; dv=0 -> IDLE, no output.
REQ-021 DATA: each dv=1 byte enters a one-byte hold register; the previously held byte is emitted with rx_valid=1.
REQ-022 DATA, dv falls: held byte emitted with rx_eof=1; FSM -> IDLE.
REQ-023 Fixed latency: data byte sampled at cycle N appears on rx_data at cycle N+2 when not last; the last byte appears one cycle after dv falls.
REQ-024 rx_sof asserted only with the first emitted byte of a frame; a one-byte frame asserts rx_sof and rx_eof together.
REQ-025 SFD followed immediately by dv=0 (zero data bytes): no rx_valid, no rx_eof.
REQ-026 er=1 while dv=1 in DATA sets a per-frame sticky error; rx_err=1 with that frame's rx_eof; sticky cleared at the next SFD.
REQ-027 Byte counter counts accepted data bytes, width clog2(MAX_FRAME_LEN+2), saturating.
REQ-028 A data byte that would make the count exceed MAX_FRAME_LEN: the held byte is emitted with rx_eof=1 and rx_err=1; FSM -> DROP; the overflow byte is discarded.
REQ-029 DROP: discard all bytes, no outputs; dv=0 -> IDLE.
REQ-030 rx_valid, rx_sof, rx_eof, rx_err are single-cycle pulses, 0 whenever not asserted by REQ-021..028.
REQ-031 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-032 Reset asserted: FSM=IDLE, hold register, counters, sticky error, rx_data=0x00, rx_valid=rx_sof=rx_eof=rx_err=0, link_up=0, speed=2'b00, full_duplex=0.
REQ-033 Reset mid-frame: frame is abandoned, no rx_eof issued; after release, framing restarts in IDLE and any dv=1 already in progress is treated per REQ-019.

Configuration
REQ-034 Macro RGMII_RX_INBAND_STATUS_EN defined: in IDLE with dv=0 and er=0, register link_up=rxd_a[0], speed=rxd_a[2:1], full_duplex=rxd_a[3] every cycle; values held otherwise.
REQ-035 Macro undefined: link_up=1, speed=2'b10, full_duplex=1 after reset release; no status register logic.

Verification
REQ-036 7x0x55, 0xD5, bytes 0x01..0x40, dv low -> 64 rx_valid pulses, rx_sof on 0x01, rx_eof on 0x40, rx_err=0, latency 2 cycles.
REQ-037 Same frame with er=1 on byte 0x10 -> same 64 bytes, rx_eof with rx_err=1; next clean frame has rx_err=0.
REQ-038 Preamble 0x55,0x55,0xAA,... -> no outputs until dv low; following good frame received normally.
REQ-039 MAX_FRAME_LEN=16, frame of 20 data bytes -> 16 bytes out, rx_eof+rx_err on byte 16, nothing further until next frame.
REQ-040 Macro defined, idle rxd_a=4'b1101 -> link_up=1, speed=2'b10, full_duplex=1; macro undefined -> constants regardless of rxd_a.
REQ-041 Reset asserted after byte 5 of a frame -> no rx_eof; outputs at reset values; next complete frame received intact.
